// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and helpers for the seven-segment scan controller.
// The helper highest_nonzero is only referenced when SSD_LZ_BLANK_EN is defined.
package ssd_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;

  // All-ones anode pattern (every common-anode digit switched off), sliced by users.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Index of the most significant non-zero digit; 0 when every digit is zero.
  function automatic logic [2:0] highest_nonzero(input logic [BCD_W*MAX_DIGITS-1:0] vals);
    logic [2:0] hi;
    hi = 3'd0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (vals[k*BCD_W +: BCD_W] != '0) hi = 3'(k);
    end
    return hi;
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// ssd_slot_timer: slot counter and digit index for the scan controller.
// All outputs are look-ahead decodes: they describe the slot position the
// counter will hold after the next clock edge, so the controller can register
// its outputs and have them line up exactly with the counter.
module ssd_slot_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             slot_end,
  output logic             frame_end,
  output logic             in_blank,
  output logic [IDX_W-1:0] idx
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic             cnt_last;
  logic             digit_last;

  // Next counter/index values and the decodes of that upcoming position.
  always_comb begin
    cnt_last   = (cnt == CNT_W'(SCAN_DIV - 1));
    digit_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_next   = cnt_last ? '0 : cnt + CNT_W'(1);
    idx_next   = idx_q;
    if (cnt_last) idx_next = digit_last ? '0 : idx_q + IDX_W'(1);
    slot_end   = (cnt_next == CNT_W'(SCAN_DIV - 1));
    frame_end  = slot_end && (idx_next == IDX_W'(NUM_DIGITS - 1));
    in_blank   = (cnt_next < CNT_W'(BLANK_CYCLES));
    idx        = idx_next;
  end

  // Slot counter wraps every SCAN_DIV cycles and steps the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx_q <= '0;
    end else begin
      cnt   <= cnt_next;
      idx_q <= idx_next;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexes one BCD-to-seven-segment decoder across
// NUM_DIGITS common-anode digits, with a dead-time blank at the start of
// every slot and a frame-stable shadow copy of the digit values.
// Optional macro SSD_LZ_BLANK_EN enables leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        load,
  output logic [BCD_W-1:0]            Count_out,
  output logic [NUM_DIGITS-1:0]       anodes,
  output logic                        frame_done,
  output logic                        pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = BCD_W * NUM_DIGITS;

  logic              slot_end;
  logic              frame_end;
  logic              in_blank;
  logic [IDX_W-1:0]  idx;

  scan_state_t       state;
  logic [DW-1:0]     staging;
  logic [DW-1:0]     shadow;
  logic [DW-1:0]     shadow_next;
  logic [NUM_DIGITS-1:0] one_hot;
  logic [NUM_DIGITS-1:0] lit_mask;
  logic [BCD_W-1:0]  next_code;
`ifdef SSD_LZ_BLANK_EN
  logic [BCD_W*MAX_DIGITS-1:0] shadow_wide;
`endif

  ssd_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .frame_end(frame_end),
    .in_blank (in_blank),
    .idx      (idx)
  );

  // Shadow value after the coming edge: swaps only on the frame boundary,
  // where a same-cycle load bypasses staging and wins over the staged value.
  always_comb begin
    shadow_next = shadow;
    if (frame_done) begin
      if (load)         shadow_next = digits_in;
      else if (pending) shadow_next = staging;
    end
    next_code = shadow_next[int'(idx)*BCD_W +: BCD_W];
  end

  // Anode pattern for the upcoming SHOW window of digit idx.
  always_comb begin
    one_hot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    lit_mask = ~one_hot;
`ifdef SSD_LZ_BLANK_EN
    shadow_wide             = '0;
    shadow_wide[DW-1:0]     = shadow;
    if (int'(idx) > int'(highest_nonzero(shadow_wide))) lit_mask = ANODE_OFF[NUM_DIGITS-1:0];
`endif
  end

  // Staging/shadow handshake: loads park in staging until the frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (load) staging <= digits_in;
      if (frame_done)  pending <= 1'b0;
      else if (load)   pending <= 1'b1;
    end
  end

  // Scan FSM with registered anode, code and frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      anodes     <= ANODE_OFF[NUM_DIGITS-1:0];
      Count_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end && slot_end;
      if (in_blank) Count_out <= next_code;
      case (state)
        BLANK: begin
          if (!in_blank) begin
            state  <= SHOW;
            anodes <= lit_mask;
          end
        end
        SHOW: begin
          if (in_blank) begin
            state  <= BLANK;
            anodes <= ANODE_OFF[NUM_DIGITS-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed bench for ssd_scan_ctrl with NUM_DIGITS=4,
// SCAN_DIV=8, BLANK_CYCLES=2. Inputs are driven and outputs sampled on the
// falling edge; cyc numbers the cycles since reset release (cycle 0 = first
// cycle out of reset).
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  Count_out;
  logic [3:0]  anodes;
  logic        frame_done;
  logic        pending;

  int          total;
  int          bad;
  int          cyc;
  logic [15:0] exp_shadow;
  logic        exp_pending;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .Count_out (Count_out),
    .anodes    (anodes),
    .frame_done(frame_done),
    .pending   (pending)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s @cyc%0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected anode pattern for a cycle of the 8-cycle slot / 4-digit frame.
  function automatic logic [3:0] exp_anodes(input int c, input logic [15:0] sh);
    int          slot_pos;
    int          d;
    logic [3:0]  one;
    slot_pos = c % 8;
    d        = (c / 8) % 4;
    one      = 4'b0001;
    if (slot_pos < 2) return 4'b1111;
`ifdef SSD_LZ_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int k = 0; k < 4; k++) if (sh[k*4 +: 4] != 4'h0) hi = k;
      if (d > hi) return 4'b1111;
    end
`endif
    return ~(one << d);
  endfunction

  // Checks every output of the current cycle against the bench's expectations.
  task automatic check_cycle();
    int d;
    d = (cyc / 8) % 4;
    check_output("anodes", 32'(anodes), 32'(exp_anodes(cyc, exp_shadow)));
    check_output("Count_out", 32'(Count_out), 32'(exp_shadow[d*4 +: 4]));
    check_output("frame_done", 32'(frame_done), 32'((cyc % 32) == 31));
    check_output("pending", 32'(pending), 32'(exp_pending));
  endtask

  // Advances one cycle and checks it.
  task automatic apply_stimulus();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) apply_stimulus();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cyc         = 0;
    exp_shadow  = 16'h0000;
    exp_pending = 1'b0;
    rst         = 1'b1;
    load        = 1'b0;
    digits_in   = 16'h0000;

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    check_output("rst_anodes", 32'(anodes), 32'h0000000f);
    check_output("rst_code", 32'(Count_out), 32'h0);
    check_output("rst_frame_done", 32'(frame_done), 32'h0);
    check_output("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    check_cycle();

    // Hand-checked start of scan: blank 2, digit 0 for 6, blank 2, digit 1.
    run_to(1);
    check_output("c1_blank", 32'(anodes), 32'h0000000f);
    run_to(2);
    check_output("c2_dig0", 32'(anodes), 32'(exp_anodes(2, 16'h0000)));
    run_to(8);
    check_output("c8_blank", 32'(anodes), 32'h0000000f);

    // Load mid-frame: staged until the frame ends.
    run_to(10);
    load        = 1'b1;
    digits_in   = 16'h1234;
    exp_pending = 1'b1;
    run_to(11);
    load = 1'b0;
    run_to(31);
    exp_shadow  = 16'h1234;
    exp_pending = 1'b0;
    run_to(33);
    check_output("f1_dig0_code", 32'(Count_out), 32'h4);

    // Double load within a frame: last value wins.
    run_to(37);
    load        = 1'b1;
    digits_in   = 16'h1111;
    exp_pending = 1'b1;
    run_to(38);
    load = 1'b0;
    run_to(52);
    load      = 1'b1;
    digits_in = 16'h9876;
    run_to(53);
    load = 1'b0;
    run_to(63);
    exp_shadow  = 16'h9876;
    exp_pending = 1'b0;
    run_to(88);
    check_output("f2_dig3_code", 32'(Count_out), 32'h9);

    // Load exactly on the frame boundary bypasses staging.
    run_to(95);
    check_output("boundary_frame_done", 32'(frame_done), 32'h1);
    load       = 1'b1;
    digits_in  = 16'h0005;
    exp_shadow = 16'h0005;
    run_to(96);
    load = 1'b0;
    check_output("boundary_code", 32'(Count_out), 32'h5);
    check_output("boundary_pending", 32'(pending), 32'h0);

    // A pending load just before a reset in the SHOW window of digit 2.
    run_to(114);
    load        = 1'b1;
    digits_in   = 16'h4321;
    exp_pending = 1'b1;
    run_to(115);
    load = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check_output("midrst_anodes", 32'(anodes), 32'h0000000f);
    check_output("midrst_code", 32'(Count_out), 32'h0);
    check_output("midrst_pending", 32'(pending), 32'h0);
    check_output("midrst_frame_done", 32'(frame_done), 32'h0);

    // Scan restarts at digit 0 with a cleared shadow.
    rst         = 1'b0;
    cyc         = 0;
    exp_shadow  = 16'h0000;
    exp_pending = 1'b0;
    check_cycle();
    run_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
